// File: rtl/systolic_n_body_2x2_cell.sv
// One PE of the 2x2 systolic n-body array: 1-D gravitational force between a row body
// and a column body, accumulated as +f into the row sum and -f into the column sum.
module systolic_n_body_2x2_cell #(
  parameter int                        WIDTH   = 32,
  parameter int                        FRAC    = 16,
  parameter logic signed [WIDTH-1:0]   G_CONST = 32'h0001_0000,
  parameter logic signed [WIDTH-1:0]   EPS2    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_q_i,
  input  logic [WIDTH-1:0] in_q_j,
  input  logic [WIDTH-1:0] in_m_i,
  input  logic [WIDTH-1:0] in_m_j,
  input  logic [WIDTH-1:0] in_p_right,
  input  logic [WIDTH-1:0] in_p_down,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_q_i,
  output logic [WIDTH-1:0] out_q_j,
  output logic [WIDTH-1:0] out_m_i,
  output logic [WIDTH-1:0] out_m_j,
  output logic [WIDTH-1:0] out_p_right,
  output logic [WIDTH-1:0] out_p_down
);

  localparam int DW = WIDTH + 1;
  localparam int SW = 2 * DW + 1;
  localparam int NW = 3 * WIDTH - FRAC;
  localparam int QW = NW + FRAC;
  localparam logic [QW-1:0]    MAG_MAX = {{(QW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [DW-1:0]      d;
  logic signed [2*DW-1:0]    dsq, d2;
  logic signed [SW-1:0]      den;
  logic signed [2*WIDTH-1:0] g_ext, mi_ext, gm, gms;
  logic signed [NW-1:0]      gms_ext, mj_ext, prod, num;
  logic [QW-1:0]             num_sh, divisor, quot;
  logic                      no_force;
  logic [WIDTH-1:0]          mag;
  logic signed [WIDTH-1:0]   f;
  logic [WIDTH:0]            sum_right, sum_down;
  logic [WIDTH-1:0]          p_right_sat, p_down_sat;

  assign d   = {in_q_j[WIDTH-1], in_q_j} - {in_q_i[WIDTH-1], in_q_i};
  assign dsq = {{DW{d[DW-1]}}, d} * {{DW{d[DW-1]}}, d};
  assign d2  = dsq >>> FRAC;
  assign den = {d2[2*DW-1], d2} + {{(SW-WIDTH){EPS2[WIDTH-1]}}, EPS2};

  assign g_ext   = {{WIDTH{G_CONST[WIDTH-1]}}, G_CONST};
  assign mi_ext  = {{WIDTH{in_m_i[WIDTH-1]}}, in_m_i};
  assign gm      = g_ext * mi_ext;
  assign gms     = gm >>> FRAC;
  assign gms_ext = {{(NW-2*WIDTH){gms[2*WIDTH-1]}}, gms};
  assign mj_ext  = {{(NW-WIDTH){in_m_j[WIDTH-1]}}, in_m_j};
  assign prod    = gms_ext * mj_ext;
  assign num     = prod >>> FRAC;
  assign num_sh  = {num, {FRAC{1'b0}}};

  // A non-positive denominator (only possible with a negative softening term) is
  // treated like coincident bodies; the divisor is forced to 1 so no X can appear.
  assign no_force = (d == '0) || den[SW-1] || (den == '0);
  assign divisor  = no_force ? {{(QW-1){1'b0}}, 1'b1} : {{(QW-SW){1'b0}}, den};
  assign quot     = num_sh / divisor;
  assign mag      = (quot > MAG_MAX) ? POS_MAX : quot[WIDTH-1:0];
  assign f        = no_force ? '0 : (d[DW-1] ? -$signed(mag) : $signed(mag));

  assign sum_right = {in_p_right[WIDTH-1], in_p_right} + {f[WIDTH-1], f};
  assign sum_down  = {in_p_down[WIDTH-1], in_p_down} - {f[WIDTH-1], f};

  // Saturate whenever the extra sign bit disagrees with the result's sign bit.
  assign p_right_sat = (sum_right[WIDTH] != sum_right[WIDTH-1])
                       ? (sum_right[WIDTH] ? NEG_MIN : POS_MAX) : sum_right[WIDTH-1:0];
  assign p_down_sat  = (sum_down[WIDTH] != sum_down[WIDTH-1])
                       ? (sum_down[WIDTH] ? NEG_MIN : POS_MAX) : sum_down[WIDTH-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_q_i     <= '0;
      out_q_j     <= '0;
      out_m_i     <= '0;
      out_m_j     <= '0;
      out_p_right <= '0;
      out_p_down  <= '0;
    end else begin
      out_valid   <= in_valid;
      out_q_i     <= in_q_i;
      out_q_j     <= in_q_j;
      out_m_i     <= in_m_i;
      out_m_j     <= in_m_j;
      out_p_right <= p_right_sat;
      out_p_down  <= p_down_sat;
    end
  end

endmodule

// File: tb/tb_systolic_n_body_2x2_cell.sv
// Directed-vector bench for systolic_n_body_2x2_cell with hand-computed Q16.16 results.
module tb_systolic_n_body_2x2_cell;

  localparam logic [31:0] ONE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_q_i = '0, in_q_j = '0, in_m_i = '0, in_m_j = '0;
  logic [31:0] in_p_right = '0, in_p_down = '0;
  logic        out_valid;
  logic [31:0] out_q_i, out_q_j, out_m_i, out_m_j, out_p_right, out_p_down;

  int checks = 0;
  int passes = 0;

  systolic_n_body_2x2_cell dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .in_q_i(in_q_i), .in_q_j(in_q_j), .in_m_i(in_m_i), .in_m_j(in_m_j),
    .in_p_right(in_p_right), .in_p_down(in_p_down),
    .out_valid(out_valid), .out_q_i(out_q_i), .out_q_j(out_q_j),
    .out_m_i(out_m_i), .out_m_j(out_m_j),
    .out_p_right(out_p_right), .out_p_down(out_p_down)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    else
      passes++;
  endtask

  // Drive one operand set, let one rising edge load it, return at the following falling edge.
  task automatic applyStimulus(input logic v, input logic [31:0] qi, input logic [31:0] qj,
                               input logic [31:0] mi, input logic [31:0] mj,
                               input logic [31:0] pr, input logic [31:0] pd);
    in_valid = v; in_q_i = qi; in_q_j = qj; in_m_i = mi; in_m_j = mj;
    in_p_right = pr; in_p_down = pd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkSet(input string tag, input logic v, input logic [31:0] qi, input logic [31:0] qj,
                          input logic [31:0] mi, input logic [31:0] mj,
                          input logic [31:0] pr, input logic [31:0] pd);
    checkOutput({tag, ".valid"},   {31'b0, out_valid}, {31'b0, v});
    checkOutput({tag, ".q_i"},     out_q_i,     qi);
    checkOutput({tag, ".q_j"},     out_q_j,     qj);
    checkOutput({tag, ".m_i"},     out_m_i,     mi);
    checkOutput({tag, ".m_j"},     out_m_j,     mj);
    checkOutput({tag, ".p_right"}, out_p_right, pr);
    checkOutput({tag, ".p_down"},  out_p_down,  pd);
  endtask

  initial begin
    $display("[TB] start");
    in_valid = 1'b1; in_q_i = 32'h1234_5678; in_q_j = 32'hDEAD_BEEF;
    in_m_i = ONE; in_m_j = ONE; in_p_right = 32'h0000_4000; in_p_down = 32'hFFFF_0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkSet("reset", 1'b0, '0, '0, '0, '0, '0, '0);

    rst = 1'b0;
    applyStimulus(1'b1, 32'h0002_0000, ONE, ONE, ONE, '0, '0);
    checkSet("basic", 1'b1, 32'h0002_0000, ONE, ONE, ONE, 32'hFFFF_0000, ONE);

    applyStimulus(1'b1, '0, 32'h0002_0000, 32'h0002_0000, ONE, 32'h0000_8000, '0);
    checkSet("accum", 1'b1, '0, 32'h0002_0000, 32'h0002_0000, ONE, ONE, 32'hFFFF_8000);

    applyStimulus(1'b1, 32'h0003_0000, 32'h0003_0000, ONE, ONE, 32'h0000_4000, 32'hFFFF_4000);
    checkSet("coinc", 1'b1, 32'h0003_0000, 32'h0003_0000, ONE, ONE, 32'h0000_4000, 32'hFFFF_4000);

    applyStimulus(1'b1, '0, 32'h0000_0100, ONE, ONE, ONE, '0);
    checkSet("satpos", 1'b1, '0, 32'h0000_0100, ONE, ONE, 32'h7FFF_FFFF, 32'h8000_0001);

    // f = -(2^31-1) drives the row sum below the minimum and the column sum above the maximum.
    applyStimulus(1'b1, 32'h0000_0100, '0, ONE, ONE, 32'h8000_0000, ONE);
    checkSet("satneg", 1'b1, 32'h0000_0100, '0, ONE, ONE, 32'h8000_0000, 32'h7FFF_FFFF);

    // Registers load even when in_valid is low; d = +1.0, masses 2.0 and 3.0 give f = +6.0.
    applyStimulus(1'b0, ONE, 32'h0002_0000, 32'h0002_0000, 32'h0003_0000, ONE, ONE);
    checkSet("novalid", 1'b0, ONE, 32'h0002_0000, 32'h0002_0000, 32'h0003_0000,
             32'h0007_0000, 32'hFFFB_0000);

    applyStimulus(1'b1, 32'h0001_0000, 32'h0001_0000, ONE, ONE, 32'h0000_1000, 32'h0000_2000);
    checkSet("streamA", 1'b1, 32'h0001_0000, 32'h0001_0000, ONE, ONE, 32'h0000_1000, 32'h0000_2000);

    in_q_i = 32'h0005_0000; in_q_j = 32'h0005_0000; in_p_right = 32'h0000_3000; in_p_down = 32'h0000_4000;
    @(posedge clk);
    #1;
    checkOutput("streamB.p_right", out_p_right, 32'h0000_3000);
    #1 rst = 1'b1;
    #1;
    checkSet("midrst", 1'b0, '0, '0, '0, '0, '0, '0);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b1, 32'h0002_0000, ONE, ONE, ONE, 32'h0000_5000, '0);
    checkSet("streamC", 1'b1, 32'h0002_0000, ONE, ONE, ONE, 32'hFFFF_5000, ONE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/systolic_n_body_2x2_cell.md
Name: systolic_n_body_2x2_cell

Overview:
- One processing element of the 2x2 systolic n-body array.
- Per clock it computes the 1-D gravitational interaction between body i (flowing left-to-right) and body j (flowing top-to-bottom).
- Adds +f_ij to the row partial-force sum and -f_ij to the column partial-force sum (Newton's third law).
- Forwards positions and masses to neighbouring cells; the accumulated sums feed the downstream systolic_n_body_2x2_integration (Verlet) stage.

Parameters:
- WIDTH, 32, total bits of every signed fixed-point data port (two's complement).
- FRAC, 16, fractional bits (default format Q16.16).
- G_CONST, 32'h0001_0000, gravitational constant in Q(WIDTH-FRAC).FRAC; default 1.0.
- EPS2, 0, softening term added to d^2, same format; default 0.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  qualifies the input operand set.
- in_q_i  in  WIDTH  position of body i (row stream).
- in_q_j  in  WIDTH  position of body j (column stream).
- in_m_i  in  WIDTH  mass of body i.
- in_m_j  in  WIDTH  mass of body j.
- in_p_right  in  WIDTH  incoming row partial force sum.
- in_p_down  in  WIDTH  incoming column partial force sum.
- out_valid  out  1  registered in_valid.
- out_q_i  out  WIDTH  registered in_q_i, to the right neighbour.
- out_q_j  out  WIDTH  registered in_q_j, to the lower neighbour.
- out_m_i  out  WIDTH  registered in_m_i.
- out_m_j  out  WIDTH  registered in_m_j.
- out_p_right  out  WIDTH  in_p_right + f_ij, registered.
- out_p_down  out  WIDTH  in_p_down - f_ij, registered.

Behaviour:
- Reset: while rst=1, all outputs including out_valid are 0 immediately, independent of clk.
- Latency: exactly 1 clock. Every output register loads on each rising clk edge regardless of in_valid.
- out_valid: follows in_valid with the same 1-cycle delay. There is no backpressure; the pipeline accepts a new operand set every cycle.
- Force arithmetic (combinational, inputs -> registers), with all intermediates at full precision:
  - d = in_q_j - in_q_i, computed in WIDTH+1 bits.
  - d2 = (d*d) >>> FRAC.
  - den = d2 + EPS2.
  - num = (((G_CONST*in_m_i) >>> FRAC) * in_m_j) >>> FRAC.
  - mag = (num << FRAC) / den, unsigned divide truncating toward zero.
  - f_ij = +mag if d > 0, -mag if d < 0.
- Coincident bodies: if d == 0, or den == 0, then f_ij = 0. No divide is performed and no X may be produced.
- Saturation:
  - mag saturates to 2^(WIDTH-1)-1 before the sign is applied.
  - out_p_right and out_p_down additions/subtractions saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap-around.
- Masses are treated as signed values with no range check. Supplying non-negative masses is the caller's responsibility.
- Pass-through outputs (q, m) are bit-exact copies of their inputs.
- A combinational divider is acceptable: single-cycle timing is the requirement, not area.
- The datapath must contain no real/float types; it must be synthesizable.

Test Plan:
- Reset: hold rst=1 with arbitrary inputs and toggling clk -> all outputs 0, out_valid=0. Deassert rst -> outputs take input values at the next rising edge.
- Basic pair: in_q_i=2.0, in_q_j=1.0, in_m_i=in_m_j=1.0, both p=0, in_valid=1. After 1 edge -> out_p_right=-1.0 (32'hFFFF_0000), out_p_down=+1.0 (32'h0001_0000), q/m outputs equal inputs, out_valid=1.
- Accumulation: in_q_i=0, in_q_j=2.0, in_m_i=2.0, in_m_j=1.0, in_p_right=0.5, in_p_down=0. Then f=+0.5 -> out_p_right=1.0, out_p_down=-0.5.
- Coincident: in_q_i=in_q_j=3.0, in_p_right=0.25, in_p_down=-0.75 -> outputs 0.25 and -0.75 unchanged, no X.
- Saturation: in_q_i=0, in_q_j=1/256 (32'h0000_0100), masses 1.0, in_p_right=1.0. mag overflows -> out_p_right=32'h7FFF_FFFF, out_p_down=-(2^31-1)+0 = 32'h8000_0001.
- Async reset mid-stream: stream 3 valid sets back-to-back, assert rst between edges -> outputs and out_valid go 0 before the next edge. After release, the next set appears 1 cycle later.
